ysyx_25040129_ifu: RTL and testbench
====================================

Name: ysyx_25040129_ifu

Overview:
Instruction fetch unit. Sits directly upstream of the instruction cache.
- Holds the PC and issues one AXI-Lite read per instruction to the I-cache.
- Delivers the fetched instruction, its PC and an error flag to the IDU over a valid/ready handshake.
- Applies redirects from EXU (branch, jump, trap, fence.i) and discards responses that a redirect has made stale.
- Forwards fence.i to the I-cache and suppresses fetch while the flush is in progress.

Parameters:
RESET_PC, 32'h8000_0000, first fetch address after reset.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
redirect_valid  in  1  one-cycle pulse: refetch from redirect_pc
redirect_pc  in  32  redirect target; bits [1:0] are ignored and forced to 0
fence_i_in  in  1  one-cycle pulse from EXU, always coincident with a redirect
fence_i_out  out  1  fence.i pulse to the I-cache
ifu_araddr  out  32  read address to the I-cache
ifu_arvalid  out  1  read address valid
ifu_arready  in  1  read address ready
ifu_rdata  in  32  instruction word
ifu_rresp  in  2  read response; 2'b00 is OKAY
ifu_rvalid  in  1  read data valid (may be high in the same cycle as the AR handshake on a hit)
ifu_rready  out  1  read data ready
inst_valid  out  1  instruction valid to the IDU
inst_ready  in  1  IDU ready
inst  out  32  instruction word
inst_pc  out  32  PC of inst
inst_err  out  1  set when the instruction's rresp was not OKAY

Behaviour:
- Reset is asynchronous: asserting rst_n low forces the following immediately, in any state, with any read in flight:
  - state=S_REQ, pc=RESET_PC, req_addr=RESET_PC, kill=0, fence_i_out=0;
  - inst, inst_pc and inst_err are cleared to 0.
- Outputs with the reset register values applied:
  - ifu_arvalid=1, ifu_rready=1, inst_valid=0.
  - ifu_araddr=RESET_PC.
- Releasing reset (rst_n high): ifu_arvalid=1 with ifu_araddr=RESET_PC from the first clock edge.
- Registers:
  - pc: next address to fetch.
  - req_addr: address of the request currently in flight.
  - kill: the in-flight response is stale and must be discarded.
- Output assignments:
  - ifu_araddr=req_addr.
  - ifu_arvalid=(state==S_REQ) && !fence_i_out.
  - ifu_rready=(state==S_REQ || state==S_RESP) && !fence_i_out.
  - inst_valid=(state==S_OUT) && !redirect_valid.
- S_REQ:
  - ifu_araddr is held stable until arvalid&&arready.
  - On the AR handshake with rvalid in the same cycle: if !kill and no redirect, latch inst, inst_pc and inst_err and go to S_OUT. Otherwise discard, clear kill, set req_addr=pc, and stay in S_REQ.
  - On the AR handshake without rvalid: go to S_RESP.
- S_RESP: on rvalid:
  - if kill is set or redirect_valid is high: discard, clear kill, set req_addr=pc, go to S_REQ;
  - otherwise: latch inst, inst_pc=req_addr, inst_err=(rresp!=OKAY), go to S_OUT.
- S_OUT: inst_valid&&inst_ready transfers the instruction; then pc=req_addr+4 (wraps mod 2^32), req_addr=req_addr+4, go to S_REQ.
- Redirect has the highest priority:
  - It sets pc=target and req_addr=target.
  - In S_REQ before arready: pc=target, kill=1; req_addr is unchanged until the AR handshake completes.
  - In S_RESP: pc=target, kill=1 (or discard directly if rvalid arrives in the same cycle).
  - In S_OUT: the instruction is dropped even if inst_ready=1; go to S_REQ with req_addr=target.
- fence.i:
  - fence_i_out is fence_i_in registered, a one-cycle pulse.
  - While fence_i_out=1, no AR and no R handshake is allowed; this keeps a stale hit from being accepted while the cache flushes.
- Latency: a cache hit costs 1 cycle to S_OUT, so peak throughput is 1 instruction per 2 cycles.
- Exactly one request is outstanding at any time.

Decomposition:
- Shared package ysyx_25040129_defs holds:
  - the RESP_OKAY/SLVERR/DECERR constants;
  - the state encodings S_REQ=2'b00, S_RESP=2'b01, S_OUT=2'b10;
  - the RESET_PC default.
- No sub-module is needed: this is a single FSM with a datapath.

Test Plan:
1. Reset, I-cache hit model returning 32'h00000013 -> first AR at 32'h80000000; inst_valid with inst_pc=32'h80000000; next AR at 32'h80000004.
2. Miss model with rvalid 5 cycles after arready -> ifu_araddr stable and arvalid held until arready; inst delivered once; no second AR before inst_ready.
3. redirect_valid (target 32'h80000100) while in S_RESP -> the old response is discarded, no inst_valid for it; next AR at 32'h80000100.
4. Redirect in S_OUT with inst_ready=1 in the same cycle -> no transfer; next AR at the target.
5. fence_i_in together with a redirect to 32'h80000020 -> fence_i_out high for exactly 1 cycle; arvalid and rready low during it; then AR at 32'h80000020.
6. rresp=2'b10 at pc 32'h80000008; rst_n pulsed low mid-S_RESP -> inst_err=1 for that instruction; after reset, fetch restarts at RESET_PC with all outputs at their reset values.

Source files
------------

// File: rtl/ysyx_25040129_ifu_pkg.sv
// rtl/ysyx_25040129_ifu_pkg.sv - shared constants and state encoding for the instruction fetch unit
package ysyx_25040129_defs;

  // AXI read response codes returned by the I-cache
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // First fetch address after reset
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  // S_REQ: address phase, S_RESP: waiting for data, S_OUT: holding an instruction for the IDU
  typedef enum logic [1:0] {
    S_REQ  = 2'b00,
    S_RESP = 2'b01,
    S_OUT  = 2'b10
  } ifu_state_e;

endpackage

// File: rtl/ysyx_25040129_ifu_if.sv
// rtl/ysyx_25040129_ifu_if.sv - I-cache read channel and IDU delivery interfaces of the fetch unit
interface ysyx_25040129_icache_if;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid;
  logic        ifu_rready;

  modport master (
    output ifu_araddr, ifu_arvalid, ifu_rready,
    input  ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid
  );

  modport slave (
    input  ifu_araddr, ifu_arvalid, ifu_rready,
    output ifu_arready, ifu_rdata, ifu_rresp, ifu_rvalid
  );
endinterface

interface ysyx_25040129_idu_if;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;

  modport master (
    output inst_valid, inst, inst_pc, inst_err,
    input  inst_ready
  );

  modport slave (
    input  inst_valid, inst, inst_pc, inst_err,
    output inst_ready
  );
endinterface

// File: rtl/ysyx_25040129_ifu.sv
// rtl/ysyx_25040129_ifu.sv - single-outstanding instruction fetch FSM with redirect kill and fence.i gating
module ysyx_25040129_ifu
  import ysyx_25040129_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           redirect_valid,
  input  logic [31:0]                    redirect_pc,
  input  logic                           fence_i_in,
  output logic                           fence_i_out,
  ysyx_25040129_icache_if.master         icache,
  ysyx_25040129_idu_if.master            idu
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        kill_q, kill_d;
  logic        fence_q;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_err_q, inst_err_d;

  logic [31:0] target;
  logic        ar_hs;
  logic        r_hs;

  assign target = {redirect_pc[31:2], 2'b00};

  // No handshake of either channel while the cache is flushing for fence.i
  assign icache.ifu_araddr  = req_addr_q;
  assign icache.ifu_arvalid = (state_q == S_REQ) && !fence_q;
  assign icache.ifu_rready  = ((state_q == S_REQ) || (state_q == S_RESP)) && !fence_q;
  assign ar_hs = icache.ifu_arvalid && icache.ifu_arready;
  assign r_hs  = icache.ifu_rready && icache.ifu_rvalid;

  assign idu.inst_valid = (state_q == S_OUT) && !redirect_valid;
  assign idu.inst       = inst_q;
  assign idu.inst_pc    = inst_pc_q;
  assign idu.inst_err   = inst_err_q;
  assign fence_i_out    = fence_q;

  // Next state: a response is either latched for the IDU or discarded when stale or redirected
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    kill_d     = kill_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    inst_err_d = inst_err_q;
    unique case (state_q)
      S_REQ: begin
        // The address already on the bus must complete, so a redirect only marks it stale
        if (redirect_valid) begin
          pc_d   = target;
          kill_d = 1'b1;
        end
        if (ar_hs) begin
          if (r_hs) begin
            if (!kill_q && !redirect_valid) begin
              inst_d     = icache.ifu_rdata;
              inst_pc_d  = req_addr_q;
              inst_err_d = (icache.ifu_rresp != RESP_OKAY);
              state_d    = S_OUT;
            end else begin
              kill_d     = 1'b0;
              req_addr_d = redirect_valid ? target : pc_q;
            end
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (r_hs) begin
          if (kill_q || redirect_valid) begin
            kill_d     = 1'b0;
            pc_d       = redirect_valid ? target : pc_q;
            req_addr_d = redirect_valid ? target : pc_q;
            state_d    = S_REQ;
          end else begin
            inst_d     = icache.ifu_rdata;
            inst_pc_d  = req_addr_q;
            inst_err_d = (icache.ifu_rresp != RESP_OKAY);
            state_d    = S_OUT;
          end
        end else if (redirect_valid) begin
          pc_d   = target;
          kill_d = 1'b1;
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          pc_d       = target;
          req_addr_d = target;
          state_d    = S_REQ;
        end else if (idu.inst_ready) begin
          pc_d       = req_addr_q + 32'd4;
          req_addr_d = req_addr_q + 32'd4;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // State and datapath registers; reset restarts fetch at RESET_PC immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      kill_q     <= 1'b0;
      fence_q    <= 1'b0;
      inst_q     <= 32'd0;
      inst_pc_q  <= 32'd0;
      inst_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      kill_q     <= kill_d;
      fence_q    <= fence_i_in;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      inst_err_q <= inst_err_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25040129_ifu.sv
// tb/tb_ysyx_25040129_ifu.sv - randomized scoreboard bench for the instruction fetch unit
module tb_ysyx_25040129_ifu;
  import ysyx_25040129_defs::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        fence_i_in = 1'b0;
  logic        fence_i_out;

  ysyx_25040129_icache_if ic ();
  ysyx_25040129_idu_if    id ();

  ysyx_25040129_ifu #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fence_i_in     (fence_i_in),
    .fence_i_out    (fence_i_out),
    .icache         (ic),
    .idu            (id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] push_pc;
  int          checks = 0;
  int          errors = 0;
  int          transfers = 0;

  // Memory image seen through the I-cache
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a - RST_PC) * 32'h9E37_79B1 + 32'h0000_0013;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [31:0] a);
    if (a[5:2] == 4'd2) return 2'b10;
    if (a[6:2] == 5'd13) return 2'b11;
    if (a[7:2] == 6'd37) return 2'b01;
    return 2'b00;
  endfunction

  // Architectural instruction stream: sequential from the last restart point
  function automatic void topup();
    while (exp_q.size() < 64) begin
      exp_q.push_back('{pc: push_pc, word: mem_word(push_pc), err: (mem_resp(push_pc) != 2'b00)});
      push_pc = push_pc + 32'd4;
    end
  endfunction

  function automatic void restart_stream(input logic [31:0] start);
    exp_q.delete();
    push_pc = start;
    topup();
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Handshake observations made at the falling edge, consumed by the slave model
  logic        ar_hs_n = 1'b0;
  logic        r_hs_n = 1'b0;
  logic [31:0] ar_addr_n = 32'd0;

  // I-cache slave model: hits answer in the AR cycle, misses after 1..6 cycles
  logic        s_pend = 1'b0;
  int          s_cnt = 0;
  logic [31:0] s_addr = 32'd0;

  initial begin : slave
    ic.ifu_arready = 1'b0;
    ic.ifu_rvalid  = 1'b0;
    ic.ifu_rdata   = 32'd0;
    ic.ifu_rresp   = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        s_pend = 1'b0;
        ic.ifu_arready = 1'b0;
        ic.ifu_rvalid  = 1'b0;
        ic.ifu_rdata   = 32'd0;
        ic.ifu_rresp   = 2'b00;
        continue;
      end
      if (r_hs_n) s_pend = 1'b0;
      if (ar_hs_n && !r_hs_n) begin
        s_pend = 1'b1;
        s_cnt  = $urandom_range(0, 5);
        s_addr = ar_addr_n;
      end
      ic.ifu_rvalid = 1'b0;
      ic.ifu_rdata  = 32'd0;
      ic.ifu_rresp  = 2'b00;
      if (s_pend) begin
        ic.ifu_arready = 1'b0;
        if (s_cnt > 0) begin
          s_cnt--;
        end else begin
          ic.ifu_rvalid = 1'b1;
          ic.ifu_rdata  = mem_word(s_addr);
          ic.ifu_rresp  = mem_resp(s_addr);
        end
      end else if (ic.ifu_arvalid && ($urandom % 10) < 7) begin
        ic.ifu_arready = 1'b1;
        if ($urandom % 2 == 0) begin
          ic.ifu_rvalid = 1'b1;
          ic.ifu_rdata  = mem_word(ic.ifu_araddr);
          ic.ifu_rresp  = mem_resp(ic.ifu_araddr);
        end
      end else begin
        ic.ifu_arready = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every IDU transfer and checks bus protocol rules
  initial begin : monitor
    logic        hold_ar;
    logic [31:0] hold_addr;
    logic        hold_inst;
    logic [31:0] hold_word;
    logic [31:0] hold_pc;
    logic        hold_err;
    logic        prev_fin;
    int          idle;
    exp_t        e;
    hold_ar = 1'b0; hold_addr = 32'd0; hold_inst = 1'b0; hold_word = 32'd0;
    hold_pc = 32'd0; hold_err = 1'b0; prev_fin = 1'b0; idle = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_ar = 1'b0; hold_inst = 1'b0; prev_fin = 1'b0; idle = 0;
        ar_hs_n = 1'b0; r_hs_n = 1'b0;
        continue;
      end
      ar_hs_n   = ic.ifu_arvalid && ic.ifu_arready;
      r_hs_n    = ic.ifu_rvalid && ic.ifu_rready;
      ar_addr_n = ic.ifu_araddr;
      if (ar_hs_n) check("ar_align", {30'd0, ic.ifu_araddr[1:0]}, 32'd0);
      if (hold_ar) begin
        check("ar_hold_addr", ic.ifu_araddr, hold_addr);
        if (!fence_i_out) check("ar_hold_valid", {31'd0, ic.ifu_arvalid}, 32'd1);
      end
      hold_ar   = (ic.ifu_arvalid && !ic.ifu_arready) || (hold_ar && fence_i_out);
      hold_addr = ic.ifu_araddr;
      if (fence_i_out || prev_fin) check("fence_pulse", {31'd0, fence_i_out}, {31'd0, prev_fin});
      if (fence_i_out) begin
        check("fence_arvalid", {31'd0, ic.ifu_arvalid}, 32'd0);
        check("fence_rready", {31'd0, ic.ifu_rready}, 32'd0);
      end
      prev_fin = fence_i_in;
      if (hold_inst) begin
        check("inst_hold_word", id.inst, hold_word);
        check("inst_hold_pc", id.inst_pc, hold_pc);
        check("inst_hold_err", {31'd0, id.inst_err}, {31'd0, hold_err});
      end
      hold_inst = id.inst_valid && !id.inst_ready;
      hold_word = id.inst; hold_pc = id.inst_pc; hold_err = id.inst_err;
      if (id.inst_valid && id.inst_ready) begin
        transfers++;
        idle = 0;
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("inst_pc", id.inst_pc, e.pc);
          check("inst", id.inst, e.word);
          check("inst_err", {31'd0, id.inst_err}, {31'd0, e.err});
        end
      end else begin
        idle++;
        if (idle > 400) begin
          check("progress_timeout", 32'd0, 32'd1);
          idle = 0;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_araddr"}, ic.ifu_araddr, RST_PC);
    check({tag, "_arvalid"}, {31'd0, ic.ifu_arvalid}, 32'd1);
    check({tag, "_rready"}, {31'd0, ic.ifu_rready}, 32'd1);
    check({tag, "_inst_valid"}, {31'd0, id.inst_valid}, 32'd0);
    check({tag, "_fence_out"}, {31'd0, fence_i_out}, 32'd0);
    check({tag, "_inst"}, id.inst, 32'd0);
    check({tag, "_inst_pc"}, id.inst_pc, 32'd0);
    check({tag, "_inst_err"}, {31'd0, id.inst_err}, 32'd0);
  endtask

  // One stimulus cycle: IDU backpressure and occasional redirects, some carrying fence.i
  task automatic run_cycle(input bit allow_redirect);
    logic [31:0] tgt;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    fence_i_in     = 1'b0;
    redirect_pc    = $urandom;
    id.inst_ready  = ($urandom % 4) != 0;
    if (allow_redirect && ($urandom % 25) == 0) begin
      if ($urandom % 8 == 0) tgt = 32'hFFFF_FFF0 + ($urandom % 4) * 4;
      else tgt = RST_PC + ($urandom % 256) * 4;
      redirect_pc    = tgt | {30'd0, 2'($urandom)};
      redirect_valid = 1'b1;
      if ($urandom % 3 == 0) fence_i_in = 1'b1;
      restart_stream(tgt);
    end
    topup();
  endtask

  initial begin : main
    bit found;
    id.inst_ready = 1'b0;
    restart_stream(RST_PC);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("release_arvalid", {31'd0, ic.ifu_arvalid}, 32'd1);
    check("release_araddr", ic.ifu_araddr, RST_PC);

    for (int i = 0; i < 1500; i++) run_cycle(i >= 40);

    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      run_cycle(1'b0);
      #1;
      if (s_pend) begin
        found = 1'b1;
        break;
      end
    end
    check("find_resp_wait", {31'd0, found}, 32'd1);
    #1 rst_n = 1'b0;
    restart_stream(RST_PC);
    #1 check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rerelease_arvalid", {31'd0, ic.ifu_arvalid}, 32'd1);
    check("rerelease_araddr", ic.ifu_araddr, RST_PC);

    for (int i = 0; i < 1500; i++) run_cycle(i >= 40);
    for (int i = 0; i < 20; i++) run_cycle(1'b0);
    check("transfer_count_min", {31'd0, transfers >= 200}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
